pmem_burst_responder: RTL and testbench
=======================================

Name: pmem_burst_responder

Overview:
- Physical-memory end of the 32-bit word-serial pmem interface; sits below the cache-line adaptor, or stands in for DRAM in simulation and FPGA builds.
- Accepts line-sized read/write requests and serves each one as an 8-beat burst of 32-bit words after a programmable latency.
- Backed by an internal synchronous word RAM.

Parameters:
- ADDR_WIDTH, 32, width of mem_address.
- DEPTH_LINES, 256, number of 32-byte lines stored; power of two.
- LATENCY, 4, idle cycles between request acceptance and first beat; legal range 0..15.
- BEATS, 8, words per line; fixed at 8.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  line read request; level, held until final beat.
- mem_write  input  1  line write request; level, held until final beat.
- mem_address  input  ADDR_WIDTH  byte address of line; bits [4:0] ignored.
- mem_wdata  input  32  write beat data.
- mem_byte_enable  input  4  per-byte write mask for current beat.
- mem_rdata  output  32  read beat data.
- mem_resp  output  1  beat strobe; one pulse per beat, 8 per transaction.
- busy  output  1  high in any state other than IDLE.
- err_both  output  1  sticky flag: mem_read and mem_write were sampled together.

Behaviour:
- Reset values: mem_resp=0, mem_rdata=0, busy=0, err_both=0, state=IDLE. RAM contents are not cleared.
- Line index = mem_address[ADDR_WIDTH-1:5] mod DEPTH_LINES, so upper bits wrap. Word address = line*8 + beat, with beat 0 the lowest word.
- Address and request type are latched in IDLE on the acceptance cycle T. Later changes to mem_address during the transaction are ignored.
- States:
  - IDLE: if mem_read or mem_write is high, latch the request and go to WAIT. If LATENCY=0, go directly to RBURST/WBURST.
  - WAIT: count LATENCY cycles, then go to RBURST or WBURST.
  - RBURST / WBURST: mem_resp=1 for 8 consecutive cycles, beat counter 0..7. After beat 7, go to DONE.
  - DONE: one turnaround cycle with mem_resp=0. Requests are ignored here. Then return to IDLE.
- Latency: the first mem_resp is at cycle T+1+LATENCY. Beat k is at cycle T+1+LATENCY+k. Bursts are never interrupted or stalled.
- Read:
  - mem_rdata is valid only in cycles where mem_resp=1 and holds word k on the k-th beat.
  - mem_rdata=0 whenever mem_resp=0.
  - RAM read is prefetched so there are no bubbles.
- Write:
  - On each rising edge where mem_resp=1, store mem_wdata for the current beat.
  - Only bytes with mem_byte_enable[i]=1 are updated; the other bytes are preserved.
  - The controller must present beat k's data while the k-th mem_resp is high.
- mem_read and mem_write both high at acceptance: treat as a read, drop the write, set err_both=1. err_both clears only on rst.
- Read-after-write to the same line returns the new data; the DONE cycle guarantees the last write has committed.
- Controller keeps its request high through the final beat and drops it afterward. If still high in DONE it is ignored; if still high in IDLE it is a new request.
- rst mid-burst: on the next cycle mem_resp=0, busy=0, state=IDLE. Beats already written remain in RAM; the rest of that line is unchanged.

Test Plan:
1. LATENCY=4: write line 0x40 with words 0x11111111..0x88888888, be=F, request at cycle T -> mem_resp high cycles T+5..T+12, busy falls after DONE. Read 0x40 -> rdata sequence 0x11111111..0x88888888 on beats 0..7.
2. Write beat 2 of line 0x40 with 0xAABBCCDD, be=4'b0011, all other beats be=0 -> read returns beat 2 = 0x3333CCDD; other beats unchanged.
3. DEPTH_LINES=256: write line at 0x2004 -> read 0x0000 returns the same 8 words (wrap, and low bits ignored).
4. mem_read and mem_write asserted together at 0x40 -> read burst of the stored line, RAM unchanged, err_both=1 held until rst.
5. rst after beat 3 of a read -> next cycle mem_resp=0, busy=0. A new read at cycle T' gives 8 beats starting T'+1+LATENCY.
6. LATENCY=0, mem_read held high continuously -> beats at T+1..T+8, DONE at T+9, re-accept at T+10, next beats T+11..T+18.

Source files
------------

// File: rtl/pmem_burst_responder_if.sv
// pmem_burst_responder_if
//   Word-serial physical-memory bus between a cache-line controller (master)
//   and the burst responder (slave). One request per line, served as a burst
//   of 32-bit beats, each beat marked by a single-cycle mem_resp pulse.
//
//   mem_read        master -> slave  line read request, held until final beat
//   mem_write       master -> slave  line write request, held until final beat
//   mem_address     master -> slave  byte address of the line
//   mem_wdata       master -> slave  write data for the current beat
//   mem_byte_enable master -> slave  per-byte write mask for the current beat
//   mem_rdata       slave -> master  read data for the current beat
//   mem_resp        slave -> master  beat strobe
interface pmem_burst_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_byte_enable;
    logic [31:0]           mem_rdata;
    logic                  mem_resp;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_rdata,
        input  mem_resp
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_rdata,
        output mem_resp
    );
endinterface

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder
//   Physical-memory end of the pmem bus. Accepts one line request at a time,
//   waits LATENCY cycles, then streams an 8-beat burst of 32-bit words from
//   (read) or into (write) an internal synchronous word RAM.
//
//   clk       rising-edge clock
//   rst       synchronous, active-high reset (RAM contents are kept)
//   bus       pmem slave port (see pmem_burst_responder_if)
//   busy      high whenever the FSM is not IDLE
//   err_both  sticky: read and write were requested together at acceptance
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for mem_read / mem_write; latches line and type
//   WAIT   | counting LATENCY cycles before the first beat
//   RBURST | 8 read beats, mem_resp high, mem_rdata = word[beat]
//   WBURST | 8 write beats, mem_resp high, RAM written each beat
//   DONE   | one turnaround cycle, requests ignored
module pmem_burst_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4,
    parameter int BEATS       = 8
) (
    input  logic clk,
    input  logic rst,
    pmem_burst_responder_if.slave bus,
    output logic busy,
    output logic err_both
);

    localparam int LINE_W      = $clog2(DEPTH_LINES);
    localparam int WORD_AW     = LINE_W + 3;
    localparam int DEPTH_WORDS = DEPTH_LINES * BEATS;

    // Wait counter is a down-counter loaded with LATENCY-1 on acceptance, so
    // WAIT lasts exactly LATENCY cycles and the first beat lands on T+1+LATENCY.
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        RBURST = 3'd2,
        WBURST = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LINE_W-1:0]   line_q;
    logic                is_read_q;
    logic [2:0]          beat_q;
    logic [3:0]          lat_q;

    logic [31:0]         ram [DEPTH_WORDS];
    logic [31:0]         ram_q;
    logic [LINE_W-1:0]   rd_line;
    logic [2:0]          rd_beat;
    logic [WORD_AW-1:0]  rd_addr;
    logic [WORD_AW-1:0]  wr_addr;

    logic                req;
    logic                accept;
    logic [LINE_W-1:0]   addr_line;

    // Only the line-index bits of the address matter; the byte offset and
    // anything above DEPTH_LINES simply wrap.
    logic                unused_addr;
    assign unused_addr = ^bus.mem_address;

    assign addr_line = bus.mem_address[5 +: LINE_W];
    assign req       = bus.mem_read | bus.mem_write;
    assign accept    = (state_q == IDLE) && req;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        // A simultaneous read+write is served as a read.
                        state_d = bus.mem_read ? RBURST : WBURST;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = is_read_q ? RBURST : WBURST;
                end
            end
            RBURST, WBURST: begin
                if (beat_q == 3'(BEATS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter, beat counter, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q    <= '0;
            is_read_q <= 1'b0;
            beat_q    <= 3'd0;
            lat_q     <= 4'd0;
            err_both  <= 1'b0;
        end else begin
            if (accept) begin
                line_q    <= addr_line;
                is_read_q <= bus.mem_read;
                beat_q    <= 3'd0;
                lat_q     <= LAT_LOAD;
                if (bus.mem_read && bus.mem_write) begin
                    err_both <= 1'b1;
                end
            end
            if (state_q == WAIT && lat_q != 4'd0) begin
                lat_q <= lat_q - 4'd1;
            end
            if (state_q == RBURST || state_q == WBURST) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM read prefetch: the address presented one cycle ahead of each beat
    // is the word that beat needs. In IDLE the live request address is used
    // so that LATENCY=0 still has beat 0 ready on T+1.
    // ------------------------------------------------------------------
    always_comb begin
        rd_line = line_q;
        rd_beat = 3'd0;
        if (state_q == IDLE) begin
            rd_line = addr_line;
        end
        if (state_q == RBURST) begin
            rd_beat = beat_q + 3'd1;
        end
    end

    assign rd_addr = {rd_line, rd_beat};
    assign wr_addr = {line_q, beat_q};

    always_ff @(posedge clk) begin
        ram_q <= ram[rd_addr];
    end

    // Byte-masked write on each write beat; a reset edge does not commit.
    always_ff @(posedge clk) begin
        if (!rst && state_q == WBURST) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_byte_enable[i]) begin
                    ram[wr_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'd0;
        busy          = (state_q != IDLE);
        if (state_q == RBURST) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = ram_q;
        end
        if (state_q == WBURST) begin
            bus.mem_resp = 1'b1;
        end
    end

endmodule

// File: tb/tb_pmem_burst_responder.sv
module tb_pmem_burst_responder;

    logic clk;
    logic rst;
    logic busy_a, err_a, busy_b, err_b;

    int checks = 0;
    int errors = 0;

    pmem_burst_responder_if #(.ADDR_WIDTH(32)) bus_a ();
    pmem_burst_responder_if #(.ADDR_WIDTH(32)) bus_b ();

    pmem_burst_responder #(.ADDR_WIDTH(32), .DEPTH_LINES(256), .LATENCY(4), .BEATS(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .err_both(err_a)
    );

    pmem_burst_responder #(.ADDR_WIDTH(32), .DEPTH_LINES(256), .LATENCY(0), .BEATS(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .err_both(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] wd [8];
    logic [3:0]  be [8];
    logic [31:0] rw [8];
    logic [31:0] exp_line [8];
    int          first_cyc, last_cyc, nbeats;
    logic        done_busy, idle_busy, timeout, rd_leak;

    // Drives one transaction on bus_a (LATENCY=4 instance). Cycle 0 is the
    // acceptance cycle T; first_cyc/last_cyc are beat offsets from T.
    task automatic run_a(input logic rd, input logic wr, input logic [31:0] addr);
        first_cyc = -1; last_cyc = -1; nbeats = 0; timeout = 1'b1; rd_leak = 1'b0;
        done_busy = 1'b0; idle_busy = 1'b1;
        @(negedge clk);
        bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_address = addr;
        bus_a.mem_wdata = 32'd0; bus_a.mem_byte_enable = 4'd0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus_a.mem_address = ~addr;  // must be ignored after acceptance
            if (bus_a.mem_resp) begin
                if (nbeats < 8) begin
                    rw[nbeats] = bus_a.mem_rdata;
                    bus_a.mem_wdata = wd[nbeats];
                    bus_a.mem_byte_enable = be[nbeats];
                end
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                nbeats++;
            end else begin
                if (bus_a.mem_rdata !== 32'd0) rd_leak = 1'b1;
                if (nbeats >= 8) begin
                    done_busy = busy_a;
                    bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0;
                    bus_a.mem_byte_enable = 4'd0;
                    timeout = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
        idle_busy = busy_a;
    endtask

    task automatic test_reset();
        checks++; if (bus_a.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", bus_a.mem_resp); end
        checks++; if (bus_a.mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_a.mem_rdata); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_a); end
        checks++; if (busy_b !== 1'b0 || bus_b.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_b got busy=%b resp=%b want 0 0", busy_b, bus_b.mem_resp); end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 8; k++) begin
            wd[k] = 32'h1111_1111 * (k + 1); be[k] = 4'hF; exp_line[k] = wd[k];
        end
        run_a(1'b1 ^ 1'b1, 1'b1, 32'h40);
        checks++; if (timeout) begin errors++; $display("FAIL wr_timeout got nbeats=%0d want 8", nbeats); end
        checks++; if (first_cyc !== 5 || last_cyc !== 12) begin errors++; $display("FAIL wr_timing got %0d..%0d want 5..12", first_cyc, last_cyc); end
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL wr_beats got %0d want 8", nbeats); end
        checks++; if (done_busy !== 1'b1 || idle_busy !== 1'b0) begin errors++; $display("FAIL wr_busy got done=%b idle=%b want 1 0", done_busy, idle_busy); end
        run_a(1'b1, 1'b0, 32'h40);
        checks++; if (first_cyc !== 5 || last_cyc !== 12) begin errors++; $display("FAIL rd_timing got %0d..%0d want 5..12", first_cyc, last_cyc); end
        checks++; if (rd_leak) begin errors++; $display("FAIL rd_leak got nonzero want 0 outside beats"); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rw[k] !== exp_line[k]) begin errors++; $display("FAIL rd_word%0d got %h want %h", k, rw[k], exp_line[k]); end
        end
    endtask

    task automatic test_byte_enable();
        for (int k = 0; k < 8; k++) begin wd[k] = 32'hFFFF_FFFF; be[k] = 4'h0; end
        wd[2] = 32'hAABB_CCDD; be[2] = 4'b0011;
        exp_line[2] = 32'h3333_CCDD;
        run_a(1'b0, 1'b1, 32'h40);
        run_a(1'b1, 1'b0, 32'h40);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rw[k] !== exp_line[k]) begin errors++; $display("FAIL be_word%0d got %h want %h", k, rw[k], exp_line[k]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_exp [8];
        for (int k = 0; k < 8; k++) begin wd[k] = 32'hC0DE_0000 + k; be[k] = 4'hF; wrap_exp[k] = wd[k]; end
        run_a(1'b0, 1'b1, 32'h2004);
        run_a(1'b1, 1'b0, 32'h0000);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rw[k] !== wrap_exp[k]) begin errors++; $display("FAIL wrap_word%0d got %h want %h", k, rw[k], wrap_exp[k]); end
        end
    endtask

    task automatic test_both();
        for (int k = 0; k < 8; k++) begin wd[k] = 32'hDEAD_0000 + k; be[k] = 4'hF; end
        run_a(1'b1, 1'b1, 32'h40);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rw[k] !== exp_line[k]) begin errors++; $display("FAIL both_rd%0d got %h want %h", k, rw[k], exp_line[k]); end
        end
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL both_err got %b want 1", err_a); end
        run_a(1'b1, 1'b0, 32'h40);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rw[k] !== exp_line[k]) begin errors++; $display("FAIL both_ram%0d got %h want %h", k, rw[k], exp_line[k]); end
        end
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL both_sticky got %b want 1", err_a); end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        bit hit;
        seen = 0; hit = 1'b0;
        @(negedge clk);
        bus_a.mem_read = 1'b1; bus_a.mem_address = 32'h40;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus_a.mem_resp) seen++;
            if (seen == 4) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_timeout got %0d beats want 4", seen); end
        rst = 1'b1; bus_a.mem_read = 1'b0;
        @(negedge clk);
        checks++; if (bus_a.mem_resp !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_idle got resp=%b busy=%b want 0 0", bus_a.mem_resp, busy_a); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", err_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_a); end
        run_a(1'b1, 1'b0, 32'h40);
        checks++; if (first_cyc !== 5 || nbeats !== 8) begin errors++; $display("FAIL rstmid_timing got first=%0d beats=%0d want 5 8", first_cyc, nbeats); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rw[k] !== exp_line[k]) begin errors++; $display("FAIL rstmid_word%0d got %h want %h", k, rw[k], exp_line[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_resp;
        @(negedge clk);
        bus_b.mem_read = 1'b1; bus_b.mem_address = 32'h80;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            exp_resp = ((c >= 1 && c <= 8) || (c >= 11 && c <= 18)) ? 1'b1 : 1'b0;
            checks++;
            if (bus_b.mem_resp !== exp_resp) begin errors++; $display("FAIL b2b_resp_c%0d got %b want %b", c, bus_b.mem_resp, exp_resp); end
            if (c == 9) begin
                checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL b2b_done_busy got %b want 1", busy_b); end
            end
            if (c == 10) begin
                checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy_b); end
            end
            if (c == 19) bus_b.mem_read = 1'b0;
        end
        @(negedge clk);
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %b want 0", busy_b); end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.mem_address = 32'd0;
        bus_a.mem_wdata = 32'd0; bus_a.mem_byte_enable = 4'd0;
        bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.mem_address = 32'd0;
        bus_b.mem_wdata = 32'd0; bus_b.mem_byte_enable = 4'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_wrap();
        test_both();
        test_reset_mid_burst();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
